bus_rr_arbiter: RTL

- Round-robin arbiter that shares one 32-bit datapath resource between four requesters, e.g. a shared memory/data bus fed by a 4:1 32-bit mux.
- It issues a one-hot grant and the matching binary mux select, and holds ownership until the resource signals completion, the owner withdraws, or a hold timeout fires.
- It sits between the requesting units (CPU data port, sprite engine, video fetch, audio) and the shared-resource input mux.

---
 rtl/bus_rr_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//
// Round-robin arbiter that shares one 32-bit datapath resource (for example
// a shared memory bus behind a 4:1 mux) between four requesters. It grants
// one requester at a time and holds that grant until one of three things
// happens: the resource signals completion, the owner withdraws its request,
// or the owner has held the grant for MAX_HOLD cycles. Every handover passes
// through one IDLE cycle with no grant, which gives the downstream mux a
// dead cycle to settle.
//
// Ports:
//   clock    - system clock, rising edge active
//   reset    - asynchronous, active-high reset
//   req      - level-sensitive request per requester, held until served
//   done     - completion strobe for the current owner (only looked at in BUSY)
//   grant    - registered one-hot grant, all zeros when idle
//   sel      - registered binary index of the owner (mux select)
//   valid    - registered, high whenever any grant bit is set
//   timeout  - registered one-cycle pulse when MAX_HOLD revoked the grant
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         sel,
    output logic               valid,
    output logic               timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // With MAX_HOLD == 0 the timeout is disabled, so the counter just
    // saturates at its all-ones value instead of at the hold limit.
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT    = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LIMIT;

    state_t               state_q,    state_d;
    logic [1:0]           ptr_q,      ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0]   grant_q,    grant_d;
    logic [1:0]           sel_q,      sel_d;
    logic                 valid_q,    valid_d;
    logic                 timeout_q,  timeout_d;

    // Arbitration search result, plus the three release causes for the owner.
    logic                 found;
    logic [1:0]           winner;
    logic                 owner_req;
    logic                 hold_expired;
    logic                 release_now;

    // Search req starting at the priority pointer and wrapping modulo 4.
    // The 2-bit add wraps naturally, so the first hit in loop order is the
    // round-robin winner.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                found  = 1'b1;
                winner = ptr_q + 2'(i);
            end
        end
    end

    // Release causes for the current owner. The timeout only counts when
    // enabled, and it is reported only when it was the sole cause.
    always_comb begin
        owner_req    = req[sel_q];
        hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT);
        release_now  = done || !owner_req || hold_expired;
    end

    // Next-state and next-output logic. Everything visible at the ports is
    // computed here and registered below, so no input reaches an output
    // without passing through a flop.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    sel_d           = winner;
                    valid_d         = 1'b1;
                    hold_cnt_d      = CNT_W'(1);
                    state_d         = BUSY;
                end else begin
                    grant_d    = '0;
                    valid_d    = 1'b0;
                    hold_cnt_d = '0;
                end
            end

            BUSY: begin
                if (release_now) begin
                    grant_d    = '0;
                    valid_d    = 1'b0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                    // The released owner drops to lowest priority.
                    ptr_d      = sel_q + 2'd1;
                    timeout_d  = hold_expired && !done && owner_req;
                end else if (hold_cnt_q != CNT_SAT) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous so that a grant
    // is dropped immediately, without waiting for a clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= 2'd0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule
